bcd_display_driver: RTL and testbench

Parametrised multi-digit 7-segment display driver. It captures a binary value on a load strobe and converts it to decimal with a sequential shift-add-3 (double-dabble) engine, or passes it through as hexadecimal nibbles. Each digit is then decoded to active-low segment patterns. It sits between datapath results and the board HEX displays, replacing single-digit combinational decoders. The display holds the last result until a new conversion completes.

---
 rtl/bcd_display_driver.sv | 208 ++++++++++++++++++++
 tb/tb_bcd_display_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_driver
// Description : Multi-digit 7-segment display driver. It captures a binary
//               value on LOAD and either converts it to BCD with a sequential
//               shift-add-3 (double-dabble) engine or passes it through as hex
//               nibbles. The result is then decoded to active-low segments.
//               HEX/OVF hold the last result until the next conversion ends.
// Ports       : CLOCK_50  - system clock (rising edge)
//               RESET_N   - asynchronous active-low reset
//               VALUE     - unsigned binary value, sampled with LOAD
//               LOAD      - start request, sampled only when idle
//               MODE      - 0 = decimal, 1 = hexadecimal (sampled with LOAD)
//               BLANK_LZ  - 1 = blank leading zero digits (sampled with LOAD)
//               BUSY      - conversion in progress
//               DONE      - one-cycle pulse when HEX/OVF take a new result
//               OVF       - last captured value exceeded the display range
//               HEX       - 7 bits per digit, bit 7i = segment a, 0 = lit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_driver #(
    parameter int DIGITS = 4,   // 1..8
    parameter int WIDTH  = 14   // 1..32
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [WIDTH-1:0]      VALUE,
    input  logic                  LOAD,
    input  logic                  MODE,
    input  logic                  BLANK_LZ,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVF,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int BW = 4 * DIGITS;
    localparam int HW = 7 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Largest displayable values for each mode.
    localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] HEX_LIM = 64'd1 << BW;

    // Segment vectors below are stored with segment a in bit 0.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;  // only g lit

    // Patterns are written in a..g reading order and reversed on return so
    // that segment a ends up in bit 0.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b0000001;
            4'h1: p = 7'b1001111;
            4'h2: p = 7'b0010010;
            4'h3: p = 7'b0000110;
            4'h4: p = 7'b1001100;
            4'h5: p = 7'b0100100;
            4'h6: p = 7'b0100000;
            4'h7: p = 7'b0001111;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0000100;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b1100000;
            4'hC: p = 7'b0110001;
            4'hD: p = 7'b1000010;
            4'hE: p = 7'b0110000;
            default: p = 7'b0111000;
        endcase
        return {p[0], p[1], p[2], p[3], p[4], p[5], p[6]};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t           state_q;
    logic [BW-1:0]    bcd_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    nib_q;      // captured VALUE as hex nibbles
    logic             mode_q;
    logic             blank_q;
    logic             ovf_cap_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [HW-1:0]    hex_q;

    logic [BW-1:0]    bcd_adj_d;
    logic [BW-1:0]    bcd_d;
    logic [BW-1:0]    src_d;
    logic [HW-1:0]    hex_d;
    logic             seen_d;
    logic [63:0]      val64_d;
    logic             ovf_d;

    // Double-dabble step: correct nibbles >= 5, then shift the next value bit in.
    // Bits leaving the top nibble are discarded; the capture-time overflow
    // check already flags those values.
    always_comb begin
        bcd_adj_d = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj_d[BW-2:0], sr_q[WIDTH-1]};
    end

    // Overflow is decided from the raw value at capture time.
    always_comb begin
        val64_d = 64'(VALUE);
        ovf_d   = MODE ? (val64_d >= HEX_LIM) : (val64_d > DEC_MAX);
    end

    // Segment decode with leading-zero blanking, scanned from the top digit
    // down; digit 0 is never blanked.
    always_comb begin
        src_d  = mode_q ? nib_q : bcd_q;
        hex_d  = '1;
        seen_d = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (src_d[4*i +: 4] != 4'd0) begin
                seen_d = 1'b1;
            end
            if (ovf_cap_q) begin
                hex_d[7*i +: 7] = SEG_DASH;
            end else if (blank_q && !seen_d && (i != 0)) begin
                hex_d[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_d[7*i +: 7] = seg_of(src_d[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            bcd_q     <= '0;
            sr_q      <= '0;
            cnt_q     <= '0;
            nib_q     <= '0;
            mode_q    <= 1'b0;
            blank_q   <= 1'b0;
            ovf_cap_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            hex_q     <= '1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (LOAD) begin
                        bcd_q     <= '0;
                        sr_q      <= VALUE;
                        cnt_q     <= CW'(WIDTH);
                        nib_q     <= BW'(VALUE);
                        mode_q    <= MODE;
                        blank_q   <= BLANK_LZ;
                        ovf_cap_q <= ovf_d;
                        busy_q    <= 1'b1;
                        state_q   <= MODE ? S_UPDATE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_q <= bcd_d;
                    sr_q  <= sr_q << 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    hex_q   <= hex_d;
                    ovf_q   <= ovf_cap_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign OVF  = ovf_q;
    assign HEX  = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_driver
// Description : Self-checking bench for bcd_display_driver (DIGITS=4,
//               WIDTH=14). Directed cases plus random values are compared
//               against an arithmetic reference model of the display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_driver;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 14;

    logic             CLOCK_50 = 1'b0;
    logic             RESET_N  = 1'b1;
    logic [WIDTH-1:0] VALUE    = '0;
    logic             LOAD     = 1'b0;
    logic             MODE     = 1'b0;
    logic             BLANK_LZ = 1'b0;
    logic             BUSY;
    logic             DONE;
    logic             OVF;
    logic [7*DIGITS-1:0] HEX;

    int total = 0;
    int bad   = 0;

    logic [7*DIGITS-1:0] shown_hex;
    logic                shown_ovf;

    bcd_display_driver #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .VALUE    (VALUE),
        .LOAD     (LOAD),
        .MODE     (MODE),
        .BLANK_LZ (BLANK_LZ),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .OVF      (OVF),
        .HEX      (HEX)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Segment patterns in a..g reading order: 0-F, then blank (16), dash (17).
    localparam logic [6:0] SEG_AG [18] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000,
        7'b1111111, 7'b1111110
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Place a..g reading order into HEX bit order (segment a in bit 0).
    function automatic logic [6:0] to_bits(input logic [6:0] p);
        logic [6:0] r;
        for (int k = 0; k < 7; k++) r[k] = p[6-k];
        return r;
    endfunction

    // Returns {ovf, hex} for a value as the display should show it.
    function automatic logic [7*DIGITS:0] model(input int unsigned v, input bit m, input bit blz);
        int unsigned d [DIGITS];
        int unsigned base;
        int unsigned p;
        int          top;
        bit          ov;
        logic [7*DIGITS-1:0] h;
        base = m ? 16 : 10;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = (v / p) % base;
            p    = p * base;
        end
        ov  = (v >= p);
        top = 0;
        for (int i = 0; i < DIGITS; i++) if (d[i] != 0) top = i;
        for (int i = 0; i < DIGITS; i++) begin
            if (ov)                  h[7*i +: 7] = to_bits(SEG_AG[17]);
            else if (blz && i > top) h[7*i +: 7] = to_bits(SEG_AG[16]);
            else                     h[7*i +: 7] = to_bits(SEG_AG[d[i]]);
        end
        return {ov, h};
    endfunction

    // Called at a negedge with the DUT idle (or in its DONE cycle). Returns at
    // the negedge on which DONE is observed.
    task automatic run_conv(input int unsigned v, input bit m, input bit blz, input bit poke);
        logic [7*DIGITS:0] e;
        int busy_n;
        bit held;
        bit got_done;
        e        = model(v, m, blz);
        VALUE    = v[WIDTH-1:0];
        MODE     = m;
        BLANK_LZ = blz;
        LOAD     = 1'b1;
        @(negedge CLOCK_50);
        LOAD = 1'b0;
        check("busy_rise", 64'(BUSY), 64'(1));
        busy_n   = 0;
        held     = 1'b1;
        got_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (DONE) begin
                got_done = 1'b1;
                break;
            end
            if (BUSY) busy_n++;
            if (HEX !== shown_hex || OVF !== shown_ovf) held = 1'b0;
            if (poke && c == 2) begin
                VALUE = 14'd5;
                LOAD  = 1'b1;
            end else begin
                LOAD = 1'b0;
            end
            @(negedge CLOCK_50);
        end
        LOAD = 1'b0;
        check("done_seen", 64'(got_done), 64'(1));
        check("busy_len", 64'(busy_n), m ? 64'(1) : 64'(WIDTH + 1));
        check("hold_while_busy", 64'(held), 64'(1));
        check("busy_low_at_done", 64'(BUSY), 64'(0));
        check($sformatf("hex_v%0d_m%0d_b%0d", v, m, blz), 64'(HEX), 64'(e[7*DIGITS-1:0]));
        check($sformatf("ovf_v%0d_m%0d", v, m), 64'(OVF), 64'(e[7*DIGITS]));
        shown_hex = e[7*DIGITS-1:0];
        shown_ovf = e[7*DIGITS];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit flag;
        int unsigned v;
        shown_hex = '1;
        shown_ovf = 1'b0;

        #1 RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_hex", 64'(HEX), 64'(28'hFFFFFFF));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_done", 64'(DONE), 64'(0));
        check("rst_ovf", 64'(OVF), 64'(0));
        RESET_N = 1'b1;
        @(negedge CLOCK_50);

        // Directed cases
        run_conv(1234, 1'b0, 1'b0, 1'b0);
        @(negedge CLOCK_50);
        check("done_one_cycle", 64'(DONE), 64'(0));
        run_conv(7, 1'b0, 1'b1, 1'b0);
        run_conv(0, 1'b0, 1'b1, 1'b0);        // LOAD in DONE cycle
        run_conv(9999, 1'b0, 1'b0, 1'b0);
        run_conv(10000, 1'b0, 1'b0, 1'b0);
        run_conv(16383, 1'b0, 1'b1, 1'b0);
        run_conv(32'h2AF, 1'b1, 1'b0, 1'b0);
        run_conv(32'h2AF, 1'b1, 1'b1, 1'b0);
        run_conv(0, 1'b1, 1'b1, 1'b0);
        run_conv(4321, 1'b0, 1'b0, 1'b1);     // LOAD while busy is ignored
        @(negedge CLOCK_50);

        // Reset during SHIFT aborts with no DONE
        VALUE = 14'd1234;
        MODE  = 1'b0;
        LOAD  = 1'b1;
        @(negedge CLOCK_50);
        LOAD = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        RESET_N = 1'b0;
        #1;
        check("abort_hex", 64'(HEX), 64'(28'hFFFFFFF));
        check("abort_busy", 64'(BUSY), 64'(0));
        check("abort_done", 64'(DONE), 64'(0));
        check("abort_ovf", 64'(OVF), 64'(0));
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        flag = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge CLOCK_50);
            if (DONE || BUSY) flag = 1'b1;
        end
        check("idle_after_reset", 64'(flag), 64'(0));
        shown_hex = '1;
        shown_ovf = 1'b0;

        // Random values, biased around the decimal range edge
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(9990, 10010);
            else                           v = $urandom_range(0, 16383);
            run_conv(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) @(negedge CLOCK_50);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
